// File: rtl/cube_moves_pkg.sv
// Cube move encodings and the corner/edge scan setup tables.
// Contents:
//   face_e / turn_e / move_t  5-bit move {face[2:0], turn[1:0]}
//   seq_state_e               sequencer FSM states
//   CornerPfx / EdgePfx       per-batch prefix move tables (6 batches x 6 slots)
//   CornerLen / EdgeLen       number of valid moves in each prefix
//   invert_move()             undo a single move (CW <-> CCW, half unchanged)
package cube_moves_pkg;

  typedef enum logic [2:0] {
    FaceU = 3'd0,
    FaceL = 3'd1,
    FaceF = 3'd2,
    FaceR = 3'd3,
    FaceB = 3'd4,
    FaceD = 3'd5
  } face_e;

  typedef enum logic [1:0] {
    TurnNone = 2'd0,
    TurnCw   = 2'd1,
    TurnHalf = 2'd2,
    TurnCcw  = 2'd3
  } turn_e;

  typedef struct packed {
    face_e face;
    turn_e turn;
  } move_t;

  typedef enum logic [1:0] {StIdle, StIssue, StWaitDone, StSettle} seq_state_e;

  localparam int unsigned NumBatches = 6;
  localparam int unsigned MaxPfxLen  = 6;

  localparam move_t MvNone = '{face: FaceU, turn: TurnNone};
  localparam move_t MvU    = '{face: FaceU, turn: TurnCw};
  localparam move_t MvUi   = '{face: FaceU, turn: TurnCcw};
  localparam move_t MvF    = '{face: FaceF, turn: TurnCw};
  localparam move_t MvFi   = '{face: FaceF, turn: TurnCcw};
  localparam move_t MvF2   = '{face: FaceF, turn: TurnHalf};
  localparam move_t MvB    = '{face: FaceB, turn: TurnCw};
  localparam move_t MvBi   = '{face: FaceB, turn: TurnCcw};
  localparam move_t MvB2   = '{face: FaceB, turn: TurnHalf};
  localparam move_t MvL    = '{face: FaceL, turn: TurnCw};
  localparam move_t MvLi   = '{face: FaceL, turn: TurnCcw};
  localparam move_t MvL2   = '{face: FaceL, turn: TurnHalf};
  localparam move_t MvR    = '{face: FaceR, turn: TurnCw};
  localparam move_t MvRi   = '{face: FaceR, turn: TurnCcw};
  localparam move_t MvR2   = '{face: FaceR, turn: TurnHalf};

  localparam move_t CornerPfx [NumBatches][MaxPfxLen] = '{
    '{MvNone, MvNone, MvNone, MvNone, MvNone, MvNone},
    '{MvF,    MvBi,   MvNone, MvNone, MvNone, MvNone},
    '{MvLi,   MvR,    MvNone, MvNone, MvNone, MvNone},
    '{MvFi,   MvB,    MvNone, MvNone, MvNone, MvNone},
    '{MvL,    MvRi,   MvNone, MvNone, MvNone, MvNone},
    '{MvL2,   MvR2,   MvNone, MvNone, MvNone, MvNone}
  };
  localparam logic [3:0] CornerLen [NumBatches] = '{4'd0, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2};

  localparam move_t EdgePfx [NumBatches][MaxPfxLen] = '{
    '{MvNone, MvNone, MvNone, MvNone, MvNone, MvNone},
    '{MvF,    MvBi,   MvL,    MvU,    MvF,    MvBi},
    '{MvLi,   MvR,    MvF,    MvUi,   MvLi,   MvR},
    '{MvFi,   MvB,    MvR,    MvU,    MvFi,   MvB},
    '{MvL,    MvRi,   MvBi,   MvU,    MvL,    MvRi},
    '{MvR2,   MvL2,   MvF2,   MvB2,   MvNone, MvNone}
  };
  localparam logic [3:0] EdgeLen [NumBatches] = '{4'd0, 4'd6, 4'd6, 4'd6, 4'd6, 4'd4};

  function automatic move_t invert_move(move_t m);
    move_t r;
    r = m;
    case (m.turn)
      TurnCw:  r.turn = TurnCcw;
      TurnCcw: r.turn = TurnCw;
      default: r.turn = m.turn;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/setup_move_sequencer_if.sv
// Handshake bundle between the sequencer, the scan FSM and the motor driver.
//   send_setup_moves / obs_index        request from scan FSM
//   move / move_valid / move_ready      move offer to motor driver
//   motor_done                          move-finished pulse from motor driver
//   color_sensor_stable / protocol_error status back to scan FSM
// Modports: master = sequencer side, slave = scan FSM / motor driver side.
interface setup_move_sequencer_if;
  import cube_moves_pkg::*;

  logic       send_setup_moves;
  logic [5:0] obs_index;
  move_t      move;
  logic       move_valid;
  logic       move_ready;
  logic       motor_done;
  logic       color_sensor_stable;
  logic       protocol_error;

  modport master (
    input  send_setup_moves, obs_index, move_ready, motor_done,
    output move, move_valid, color_sensor_stable, protocol_error
  );

  modport slave (
    output send_setup_moves, obs_index, move_ready, motor_done,
    input  move, move_valid, color_sensor_stable, protocol_error
  );
endinterface

// File: rtl/setup_move_rom.sv
// Combinational move schedule: (k, step) -> move.
// A non-empty list is U, then the postfix undoing the previous batch, then the
// prefix of batch k.
//   k_i      observation index 0..48 (values above 48 report empty)
//   step_i   step within the list
//   move_o   move at that step (MvNone past the end or when empty)
//   empty_o  list for k has no moves
//   last_o   step_i is the final step of the list
module setup_move_rom
  import cube_moves_pkg::*;
(
  input  logic [5:0] k_i,
  input  logic [3:0] step_i,
  output move_t      move_o,
  output logic       empty_o,
  output logic       last_o
);

  function automatic move_t pfx_move(logic is_edge, logic [2:0] b, logic [3:0] j);
    move_t m;
    m = MvNone;
    if (b < 3'd6 && j < 4'd6) begin
      m = is_edge ? EdgePfx[b][j[2:0]] : CornerPfx[b][j[2:0]];
    end
    return m;
  endfunction

  logic [5:0] kk;
  logic [2:0] b;
  logic       post_edge, post_fwd, pre_edge;
  logic [2:0] post_b, pre_b;
  logic [3:0] post_len, pre_len, len, j;

  always_comb begin
    kk        = (k_i >= 6'd24) ? k_i - 6'd24 : k_i;
    b         = kk[4:2];
    post_edge = 1'b0;
    post_fwd  = 1'b0;
    post_b    = 3'd0;
    post_len  = 4'd0;
    pre_edge  = 1'b0;
    pre_b     = 3'd0;
    pre_len   = 4'd0;
    len       = 4'd0;
    j         = 4'd0;
    move_o    = MvNone;

    if (k_i == 6'd48) begin
      post_edge = 1'b1;
      post_b    = 3'd5;
      post_len  = EdgeLen[5];
    end else if (k_i != 6'd0 && k_i < 6'd48 && k_i[1:0] == 2'd0) begin
      pre_edge = (k_i >= 6'd24);
      pre_b    = b;
      pre_len  = pre_edge ? EdgeLen[b] : CornerLen[b];
      if (k_i == 6'd24) begin
        // Corner b5 is two half turns on opposite faces; they commute and
        // self-invert, so the undo is the table replayed in stored order.
        post_b   = 3'd5;
        post_fwd = 1'b1;
        post_len = CornerLen[5];
      end else begin
        post_edge = pre_edge;
        post_b    = b - 3'd1;
        post_len  = pre_edge ? EdgeLen[post_b] : CornerLen[post_b];
      end
    end

    if (k_i != 6'd0 && k_i <= 6'd48) len = 4'd1 + post_len + pre_len;

    empty_o = (len == 4'd0);
    last_o  = !empty_o && (step_i == len - 4'd1);

    if (!empty_o && step_i < len) begin
      if (step_i == 4'd0) begin
        move_o = MvU;
      end else if (step_i <= post_len) begin
        j = step_i - 4'd1;
        if (post_fwd) move_o = pfx_move(post_edge, post_b, j);
        else          move_o = invert_move(pfx_move(post_edge, post_b, post_len - 4'd1 - j));
      end else begin
        j      = step_i - 4'd1 - post_len;
        move_o = pfx_move(pre_edge, pre_b, j);
      end
    end
  end

endmodule

// File: rtl/setup_move_sequencer.sv
// Issues the setup moves for each sticker observation, one move at a time, then
// waits SETTLE_CYCLES and pulses color_sensor_stable.
//   clock, reset   system clock, synchronous active-high reset
//   bus            setup_move_sequencer_if.master (request, move handshake, status)
//   total_moves    accepted-move count, saturating (only with MOVE_COUNT_EN defined)
// Optional feature macro: MOVE_COUNT_EN.
module setup_move_sequencer
  import cube_moves_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 650000,
  parameter int unsigned SETTLE_W      = 20
) (
  input  logic                          clock,
  input  logic                          reset,
  setup_move_sequencer_if.master        bus
`ifdef MOVE_COUNT_EN
  ,
  output logic [15:0]                   total_moves
`endif
);

  seq_state_e          state_q, state_d;
  logic [5:0]          k_q, k_d;
  logic [3:0]          step_q, step_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                stable_q, stable_d;

  logic [5:0] rom_k;
  logic [3:0] rom_step;
  move_t      rom_move;
  logic       rom_empty, rom_last;

  // In IDLE the ROM looks at the incoming index so the empty-list decision is
  // made on the strobe cycle itself.
  assign rom_k    = (state_q == StIdle) ? bus.obs_index : k_q;
  assign rom_step = (state_q == StIdle) ? 4'd0 : step_q;

  setup_move_rom u_rom (
    .k_i     (rom_k),
    .step_i  (rom_step),
    .move_o  (rom_move),
    .empty_o (rom_empty),
    .last_o  (rom_last)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    stable_d = 1'b0;

    if (bus.send_setup_moves && state_q != StIdle) err_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (bus.send_setup_moves) begin
          if (bus.obs_index > 6'd48) begin
            err_d = 1'b1;
          end else begin
            k_d     = bus.obs_index;
            step_d  = 4'd0;
            cnt_d   = '0;
            state_d = rom_empty ? StSettle : StIssue;
          end
        end
      end
      StIssue: begin
        if (bus.move_ready) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (bus.motor_done) begin
          if (rom_last) begin
            cnt_d   = '0;
            state_d = StSettle;
          end else begin
            step_d  = step_q + 4'd1;
            state_d = StIssue;
          end
        end
      end
      StSettle: begin
        // Registered pulse lands on the first IDLE cycle, so a strobe in that
        // same cycle is accepted.
        if (cnt_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
          stable_d = 1'b1;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      k_q      <= '0;
      step_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      stable_q <= stable_d;
    end
  end

  assign bus.move_valid          = (state_q == StIssue);
  assign bus.move                = (state_q == StIssue) ? rom_move : MvNone;
  assign bus.color_sensor_stable = stable_q;
  assign bus.protocol_error      = err_q;

`ifdef MOVE_COUNT_EN
  logic [15:0] total_q, total_d;
  logic        fire;

  assign fire = (state_q == StIssue) && bus.move_ready;

  always_comb begin
    total_d = total_q;
    if (fire && total_q != 16'hFFFF) total_d = total_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) total_q <= '0;
    else       total_q <= total_d;
  end

  assign total_moves = total_q;
`endif

endmodule

// File: tb/tb_setup_move_sequencer.sv
// Directed bench for setup_move_sequencer with SETTLE_CYCLES = 8.
module tb_setup_move_sequencer;
  import cube_moves_pkg::*;

  localparam int unsigned SettleCycles = 8;
  // Whole scan 0..48: corners 41 + edges 78 + restore 5 moves.
  localparam int unsigned ScanMoves    = 124;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned hs_count = 0;
  int unsigned stable_count = 0;
  int unsigned last_done_cyc = 0;

  setup_move_sequencer_if bus ();

`ifdef MOVE_COUNT_EN
  logic [15:0] total_moves;
`endif

  setup_move_sequencer #(
    .SETTLE_CYCLES (SettleCycles),
    .SETTLE_W      (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus)
`ifdef MOVE_COUNT_EN
    ,
    .total_moves (total_moves)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.move_valid && bus.move_ready) hs_count <= hs_count + 1;
    if (bus.color_sensor_stable) stable_count <= stable_count + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic strobe(logic [5:0] k, output int unsigned t);
    bus.obs_index        = k;
    bus.send_setup_moves = 1'b1;
    t = cyc;
    tick();
    bus.send_setup_moves = 1'b0;
  endtask

  task automatic accept_move(string tag, move_t exp, int unsigned hold);
    bit seen = 1'b0;
    bit held_ok = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.move_valid) seen = 1'b1;
      else tick();
    end
    check({tag, "_valid"}, {31'd0, seen}, 32'd1);
    if (!seen) return;
    check({tag, "_move"}, {27'd0, bus.move}, {27'd0, exp});
    for (int i = 0; i < int'(hold); i++) begin
      tick();
      if (bus.move_valid !== 1'b1 || bus.move !== exp) held_ok = 1'b0;
    end
    if (hold != 0) check({tag, "_hold"}, {31'd0, held_ok}, 32'd1);
    bus.move_ready = 1'b1;
    tick();
    bus.move_ready = 1'b0;
    check({tag, "_drop"}, {31'd0, bus.move_valid}, 32'd0);
  endtask

  task automatic finish_move();
    tick();
    tick();
    bus.motor_done = 1'b1;
    last_done_cyc  = cyc;
    tick();
    bus.motor_done = 1'b0;
  endtask

  task automatic wait_stable(string tag, int unsigned exp_cyc);
    bit          seen  = 1'b0;
    bit          stray = 1'b0;
    int unsigned at    = 32'hFFFF_FFFF;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.color_sensor_stable) begin
        seen = 1'b1;
        at   = cyc;
      end else begin
        if (bus.move_valid) stray = 1'b1;
        tick();
      end
    end
    check({tag, "_pulse_cyc"}, at, exp_cyc);
    check({tag, "_no_move"}, {31'd0, stray}, 32'd0);
    tick();
    check({tag, "_one_cycle"}, {31'd0, bus.color_sensor_stable}, 32'd0);
  endtask

  // Quiet window: no move offered and no stable pulse.
  task automatic expect_quiet(string tag, int unsigned cycles);
    bit noise = 1'b0;
    for (int i = 0; i < int'(cycles); i++) begin
      if (bus.move_valid || bus.color_sensor_stable) noise = 1'b1;
      tick();
    end
    check({tag, "_quiet"}, {31'd0, noise}, 32'd0);
  endtask

  task automatic service(string tag);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (bus.color_sensor_stable) begin
        done = 1'b1;
      end else if (bus.move_valid) begin
        bus.move_ready = 1'b1;
        tick();
        bus.move_ready = 1'b0;
        tick();
        bus.motor_done = 1'b1;
        tick();
        bus.motor_done = 1'b0;
      end else begin
        tick();
      end
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    tick();
  endtask

  initial begin
    int unsigned t;
    int unsigned h0;
    int unsigned s0;

    bus.send_setup_moves = 1'b0;
    bus.obs_index        = 6'd0;
    bus.move_ready       = 1'b0;
    bus.motor_done       = 1'b0;

    do_reset();
    check("rst_valid",  {31'd0, bus.move_valid}, 32'd0);
    check("rst_move",   {27'd0, bus.move}, 32'd0);
    check("rst_stable", {31'd0, bus.color_sensor_stable}, 32'd0);
    check("rst_err",    {31'd0, bus.protocol_error}, 32'd0);

    // k=0: empty list, pulse at strobe + 1 + SETTLE_CYCLES.
    strobe(6'd0, t);
    wait_stable("k0", t + 1 + SettleCycles);

    // k=1: single U.
    strobe(6'd1, t);
    accept_move("k1_u", 5'b000_01, 0);
    finish_move();
    wait_stable("k1", last_done_cyc + 1 + SettleCycles);

    // k=4: U, F, B' with F held off for 5 cycles.
    strobe(6'd4, t);
    accept_move("k4_u", 5'b000_01, 0);
    finish_move();
    accept_move("k4_f", 5'b010_01, 5);
    finish_move();
    accept_move("k4_bi", 5'b100_11, 0);
    finish_move();
    wait_stable("k4", last_done_cyc + 1 + SettleCycles);

    // k=24: corner-to-edge crossover.
    strobe(6'd24, t);
    accept_move("k24_u", 5'b000_01, 0);
    finish_move();
    accept_move("k24_l2", 5'b001_10, 0);
    finish_move();
    accept_move("k24_r2", 5'b011_10, 0);
    finish_move();
    wait_stable("k24", last_done_cyc + 1 + SettleCycles);

    // k=48: restore.
    strobe(6'd48, t);
    accept_move("k48_u", 5'b000_01, 0);
    finish_move();
    accept_move("k48_b2", 5'b100_10, 0);
    finish_move();
    accept_move("k48_f2", 5'b010_10, 0);
    finish_move();
    accept_move("k48_l2", 5'b001_10, 0);
    finish_move();
    accept_move("k48_r2", 5'b011_10, 0);
    finish_move();
    wait_stable("k48", last_done_cyc + 1 + SettleCycles);
    check("clean_err", {31'd0, bus.protocol_error}, 32'd0);

    // Strobe while waiting for motor_done: flagged, sequence unaffected.
    strobe(6'd1, t);
    accept_move("busy_u", 5'b000_01, 0);
    strobe(6'd2, t);
    check("busy_err", {31'd0, bus.protocol_error}, 32'd1);
    finish_move();
    wait_stable("busy", last_done_cyc + 1 + SettleCycles);

    // Out-of-range index: error, nothing issued, FSM remains idle.
    do_reset();
    strobe(6'd50, t);
    check("oor_err", {31'd0, bus.protocol_error}, 32'd1);
    expect_quiet("oor", 15);
    strobe(6'd0, t);
    wait_stable("oor_idle", t + 1 + SettleCycles);

    // Reset while waiting for motor_done; late motor_done ignored.
    do_reset();
    strobe(6'd4, t);
    accept_move("rstw_u", 5'b000_01, 0);
    strobe(6'd3, t);
    check("rstw_err_set", {31'd0, bus.protocol_error}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstw_valid",  {31'd0, bus.move_valid}, 32'd0);
    check("rstw_move",   {27'd0, bus.move}, 32'd0);
    check("rstw_stable", {31'd0, bus.color_sensor_stable}, 32'd0);
    check("rstw_err",    {31'd0, bus.protocol_error}, 32'd0);
    bus.motor_done = 1'b1;
    tick();
    bus.motor_done = 1'b0;
    expect_quiet("rstw_late", 12);
    strobe(6'd1, t);
    accept_move("rstw_k1_u", 5'b000_01, 0);
    finish_move();
    wait_stable("rstw_k1", last_done_cyc + 1 + SettleCycles);

    // Full scan 0..48.
    do_reset();
    h0 = hs_count;
    s0 = stable_count;
    for (int k = 0; k < 49; k++) begin
      strobe(6'(k), t);
      service($sformatf("scan%0d", k));
    end
    check("scan_moves",   hs_count - h0, ScanMoves);
    check("scan_pulses",  stable_count - s0, 32'd49);
    check("scan_err",     {31'd0, bus.protocol_error}, 32'd0);
`ifdef MOVE_COUNT_EN
    check("scan_total",   {16'd0, total_moves}, ScanMoves);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
